hamming_stream_encoder: RTL and testbench

- Streaming, parametrised Hamming encoder. Successor to the fixed 4-bit/7-bit encoder.
- Generalises the data width and adds an optional SECDED overall-parity bit.
- Adds valid/ready handshakes with a skid buffer for full throughput, per-word error injection (to exercise downstream decoders), and a saturating count of emitted codewords.
- Sits between a data source and the channel/decoder path.

---
 rtl/hamming_stream_encoder_pkg.sv | 41 ++++
 rtl/hamming_stream_encoder_if.sv | 32 +++
 rtl/hamming_stream_encoder_encode_comb.sv | 52 +++++
 rtl/hamming_stream_encoder.sv | 116 +++++++++++
 tb/tb_hamming_stream_encoder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hamming_stream_encoder_pkg.sv
// Shared Hamming helpers: parity-bit count, power-of-two test, and the
// position-to-data-bit mapping used by both encoder and decoder.
package hamming_pkg;

  localparam int MAX_DATA_W = 57;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_t;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int calc_parity_bits(input int data_w);
    int result;
    result = 7;
    for (int p = 7; p >= 1; p--) begin
      if ((1 << p) >= data_w + p + 1) begin
        result = p;
      end
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data-bit index of in_data feeding a non-power-of-two position: the first
  // data position carries the MSB, later positions step down towards the LSB.
  function automatic int data_bit_index(input int data_w, input int pos);
    int rank;
    rank = 0;
    for (int k = 1; k < pos; k++) begin
      if (!is_pow2(k)) begin
        rank++;
      end
    end
    return data_w - 1 - rank;
  endfunction

endpackage

// File: rtl/hamming_stream_encoder_if.sv
// Source/sink stream bundle of the Hamming encoder, including error-injection
// fields and the emitted-word counter.
interface hamming_stream_encoder_if #(
  parameter int DATA_W  = 4,
  parameter int SECDED  = 0,
  parameter int COUNT_W = 16
);
  localparam int P     = hamming_pkg::calc_parity_bits(DATA_W);
  localparam int CW_W  = DATA_W + P + SECDED;
  localparam int IDX_W = $clog2(CW_W + 1);

  logic [DATA_W-1:0]  in_data;
  logic               in_inj_en;
  logic [IDX_W-1:0]   in_inj_pos;
  logic               in_valid;
  logic               in_ready;
  logic [CW_W-1:0]    out_codeword;
  logic               out_valid;
  logic               out_ready;
  logic [COUNT_W-1:0] out_count;

  modport master (
    output in_data, in_inj_en, in_inj_pos, in_valid, out_ready,
    input  in_ready, out_codeword, out_valid, out_count
  );

  modport slave (
    input  in_data, in_inj_en, in_inj_pos, in_valid, out_ready,
    output in_ready, out_codeword, out_valid, out_count
  );

endinterface

// File: rtl/hamming_stream_encoder_encode_comb.sv
// Purely combinational data-to-codeword Hamming encoder, optional SECDED bit.
// Position k of the code lands on codeword bit [CW_W-k].
module hamming_encode_comb
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int SECDED = 0,
  localparam int P     = calc_parity_bits(DATA_W),
  localparam int N     = DATA_W + P,
  localparam int CW_W  = N + SECDED
) (
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   codeword
);

  logic [N:1]   data_map;
  logic [P-1:0] parity;
  logic [N-1:0] body;

  generate
    for (genvar gi = 1; gi <= N; gi++) begin : g_pos
      if (is_pow2(gi)) begin : g_par
        assign data_map[gi] = 1'b0;
        assign body[N-gi]   = parity[$clog2(gi)];
      end else begin : g_dat
        assign data_map[gi] = data[data_bit_index(DATA_W, gi)];
        assign body[N-gi]   = data_map[gi];
      end
    end
  endgenerate

  // Parity positions hold zero in data_map, so they drop out of the XOR.
  always_comb begin
    parity = '0;
    for (int j = 0; j < P; j++) begin
      for (int k = 1; k <= N; k++) begin
        if (k[j]) begin
          parity[j] = parity[j] ^ data_map[k];
        end
      end
    end
  end

  generate
    if (SECDED != 0) begin : g_secded
      assign codeword = {body, ^body};
    end else begin : g_plain
      assign codeword = body;
    end
  endgenerate

endmodule

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming encoder: registered output stage with a one-entry skid
// buffer, per-word bit-flip injection and a saturating emitted-word counter.
module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int SECDED  = 0,
  parameter int COUNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  hamming_stream_encoder_if.slave  bus
);

  localparam int P     = calc_parity_bits(DATA_W);
  localparam int CW_W  = DATA_W + P + SECDED;
  localparam int IDX_W = $clog2(CW_W + 1);

  logic [CW_W-1:0]    encoded;
  logic [CW_W-1:0]    flip_mask;
  logic [CW_W-1:0]    in_word;

  skid_state_t        state_reg, state_next;
  logic               out_valid_reg, out_valid_next;
  logic [CW_W-1:0]    out_codeword_reg, out_codeword_next;
  logic [CW_W-1:0]    skid_codeword_reg, skid_codeword_next;
  logic               in_ready_reg, in_ready_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  logic               accept;
  logic               out_free;
  logic               out_fire;

  hamming_encode_comb #(
    .DATA_W (DATA_W),
    .SECDED (SECDED)
  ) u_encode (
    .data     (bus.in_data),
    .codeword (encoded)
  );

  // Out-of-range positions never match, so they leave the word untouched.
  generate
    for (genvar gi = 0; gi < CW_W; gi++) begin : g_inj
      assign flip_mask[gi] = bus.in_inj_en && (bus.in_inj_pos == IDX_W'(gi));
    end
  endgenerate

  assign in_word  = encoded ^ flip_mask;
  assign accept   = bus.in_valid && in_ready_reg;
  assign out_free = !out_valid_reg || bus.out_ready;
  assign out_fire = out_valid_reg && bus.out_ready;

  always_comb begin
    state_next         = state_reg;
    out_valid_next     = out_valid_reg;
    out_codeword_next  = out_codeword_reg;
    skid_codeword_next = skid_codeword_reg;
    count_next         = count_reg;

    if (out_fire && (count_reg != {COUNT_W{1'b1}})) begin
      count_next = count_reg + COUNT_W'(1);
    end

    case (state_reg)
      SKID_EMPTY: begin
        if (out_free) begin
          out_valid_next = accept;
          if (accept) begin
            out_codeword_next = in_word;
          end
        end else if (accept) begin
          skid_codeword_next = in_word;
          state_next         = SKID_FULL;
        end
      end
      // in_ready is low here, so no new word can arrive alongside the drain.
      SKID_FULL: begin
        if (out_free) begin
          out_codeword_next = skid_codeword_reg;
          out_valid_next    = 1'b1;
          state_next        = SKID_EMPTY;
        end
      end
      default: begin
        state_next = SKID_EMPTY;
      end
    endcase

    in_ready_next = (state_next == SKID_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= SKID_EMPTY;
      out_valid_reg     <= 1'b0;
      out_codeword_reg  <= '0;
      skid_codeword_reg <= '0;
      in_ready_reg      <= 1'b0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      out_valid_reg     <= out_valid_next;
      out_codeword_reg  <= out_codeword_next;
      skid_codeword_reg <= skid_codeword_next;
      in_ready_reg      <= in_ready_next;
      count_reg         <= count_next;
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_codeword = out_codeword_reg;
  assign bus.out_count    = count_reg;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Directed bench for hamming_stream_encoder: plain, SECDED and narrow-counter
// instances share one clock and reset.
module tb_hamming_stream_encoder;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hamming_stream_encoder_if #(.DATA_W(4), .SECDED(0), .COUNT_W(16)) if0 ();
  hamming_stream_encoder_if #(.DATA_W(4), .SECDED(1), .COUNT_W(16)) if1 ();
  hamming_stream_encoder_if #(.DATA_W(4), .SECDED(0), .COUNT_W(3))  if2 ();

  hamming_stream_encoder #(.DATA_W(4), .SECDED(0), .COUNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(if0));
  hamming_stream_encoder #(.DATA_W(4), .SECDED(1), .COUNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(if1));
  hamming_stream_encoder #(.DATA_W(4), .SECDED(0), .COUNT_W(3))  u2 (.clk(clk), .reset(reset), .bus(if2));

  // Reference layout {p1,p2,d3,p3,d2,d1,d0}.
  function automatic logic [6:0] ref7(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p3 = d[2] ^ d[1] ^ d[0];
    return {p1, p2, d[3], p3, d[2], d[1], d[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if0.in_data = '0; if0.in_inj_en = 1'b0; if0.in_inj_pos = '0; if0.in_valid = 1'b0; if0.out_ready = 1'b1;
    if1.in_data = '0; if1.in_inj_en = 1'b0; if1.in_inj_pos = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if2.in_data = '0; if2.in_inj_en = 1'b0; if2.in_inj_pos = '0; if2.in_valid = 1'b0; if2.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_all();
    if0.in_valid = 1'b1; if1.in_valid = 1'b1; if2.in_valid = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", if0.out_valid); end
      total++; if (if0.out_count !== 16'd0) begin bad++; $display("FAIL reset_out_count: got %0d want 0", if0.out_count); end
      total++; if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", if0.in_ready); end
      total++; if (if0.out_codeword !== 7'd0) begin bad++; $display("FAIL reset_codeword: got %b want 0", if0.out_codeword); end
      total++; if (if1.out_valid !== 1'b0 || if2.out_valid !== 1'b0) begin bad++; $display("FAIL reset_other_valid: got %b/%b want 0/0", if1.out_valid, if2.out_valid); end
    end
    reset = 1'b1;
    tick();
    total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", if0.in_ready); end
    total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %b want 0", if0.out_valid); end
    idle_all();
    tick();
    total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL release_no_accept: got %b want 0", if0.out_valid); end
    $display("reset: done");
  endtask

  task automatic test_encode();
    if0.in_data = 4'b1011; if0.in_valid = 1'b1;
    tick();
    total++; if (if0.out_valid !== 1'b1 || if0.out_codeword !== 7'b0110011) begin bad++; $display("FAIL enc_1011: got v=%b cw=%b want v=1 cw=0110011", if0.out_valid, if0.out_codeword); end
    $display("encode: data=1011 cw=%b", if0.out_codeword);
    if0.in_data = 4'b0001;
    tick();
    total++; if (if0.out_valid !== 1'b1 || if0.out_codeword !== 7'b1101001) begin bad++; $display("FAIL enc_0001: got v=%b cw=%b want v=1 cw=1101001", if0.out_valid, if0.out_codeword); end
    $display("encode: data=0001 cw=%b", if0.out_codeword);
    if0.in_valid = 1'b0;
    tick();
    total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL enc_idle_valid: got %b want 0", if0.out_valid); end
    total++; if (if0.out_count !== 16'd2) begin bad++; $display("FAIL enc_count: got %0d want 2", if0.out_count); end
  endtask

  task automatic test_inject();
    if0.in_data = 4'b1011; if0.in_valid = 1'b1; if0.in_inj_en = 1'b1; if0.in_inj_pos = 3'd6;
    tick();
    total++; if (if0.out_codeword !== 7'b1110011) begin bad++; $display("FAIL inj_pos6: got %b want 1110011", if0.out_codeword); end
    $display("inject: pos=6 cw=%b", if0.out_codeword);
    if0.in_inj_pos = 3'd7;
    tick();
    total++; if (if0.out_codeword !== 7'b0110011) begin bad++; $display("FAIL inj_pos7: got %b want 0110011", if0.out_codeword); end
    $display("inject: pos=7 cw=%b", if0.out_codeword);
    if0.in_inj_pos = 3'd0;
    tick();
    total++; if (if0.out_codeword !== 7'b0110010) begin bad++; $display("FAIL inj_pos0: got %b want 0110010", if0.out_codeword); end
    $display("inject: pos=0 cw=%b", if0.out_codeword);
    if0.in_inj_en = 1'b0; if0.in_inj_pos = 3'd6;
    tick();
    total++; if (if0.out_codeword !== 7'b0110011) begin bad++; $display("FAIL inj_disabled: got %b want 0110011", if0.out_codeword); end
    if0.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_secded();
    logic [7:0] want;
    logic [7:0] cw;
    for (int w = 0; w < 16; w++) begin
      if1.in_data = 4'(w); if1.in_valid = 1'b1;
      tick();
      cw   = if1.out_codeword;
      want = {ref7(4'(w)), ^ref7(4'(w))};
      total++; if (if1.out_valid !== 1'b1 || cw !== want) begin bad++; $display("FAIL secded_cw[%0d]: got v=%b cw=%b want cw=%b", w, if1.out_valid, cw, want); end
      total++; if ((^cw) !== 1'b0) begin bad++; $display("FAIL secded_parity[%0d]: got %b want 0", w, ^cw); end
      total++; if ({cw[5], cw[3], cw[2], cw[1]} !== 4'(w)) begin bad++; $display("FAIL secded_decode[%0d]: got %b want %b", w, {cw[5], cw[3], cw[2], cw[1]}, 4'(w)); end
      if (w == 11) begin
        total++; if (cw !== 8'b01100110) begin bad++; $display("FAIL secded_1011: got %b want 01100110", cw); end
      end
      $display("secded: data=%b cw=%b", 4'(w), cw);
    end
    if1.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] q[$];
    int         sent;
    int         recv;
    int         cyc;
    bit         acc;
    bit         fire;
    logic [3:0] acc_data;
    logic [3:0] head;
    do_reset();
    sent = 0; recv = 0; cyc = 0; acc = 0; fire = 0; acc_data = '0;
    while (recv < 16 && cyc < 400) begin
      tick();
      cyc++;
      if (acc) begin q.push_back(acc_data); sent++; end
      if (fire) begin head = q.pop_front(); recv++; end
      total++; if (if0.in_ready !== (q.size() < 2)) begin bad++; $display("FAIL bp_in_ready@%0d: got %b want %b", cyc, if0.in_ready, q.size() < 2); end
      total++; if (if0.out_valid !== (q.size() > 0)) begin bad++; $display("FAIL bp_out_valid@%0d: got %b want %b", cyc, if0.out_valid, q.size() > 0); end
      if ((cyc >= 5 && cyc < 15) || (cyc >= 25 && cyc < 40)) if0.out_ready = 1'b0;
      else if0.out_ready = 1'($urandom_range(0, 1));
      if0.in_valid = (sent < 16);
      if0.in_data  = 4'(sent);
      acc      = if0.in_valid && if0.in_ready;
      acc_data = if0.in_data;
      fire     = if0.out_valid && if0.out_ready;
      if (fire) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_spurious@%0d: got cw=%b want no word", cyc, if0.out_codeword);
        end else if (if0.out_codeword !== ref7(q[0])) begin
          bad++; $display("FAIL bp_order@%0d: got %b want %b", cyc, if0.out_codeword, ref7(q[0]));
        end
        $display("backpressure: cyc=%0d cw=%b", cyc, if0.out_codeword);
      end
    end
    total++; if (recv != 16) begin bad++; $display("FAIL bp_timeout: got %0d words want 16", recv); end
    if0.in_valid = 1'b0; if0.out_ready = 1'b1;
    tick();
    total++; if (if0.out_count !== 16'd16) begin bad++; $display("FAIL bp_count: got %0d want 16", if0.out_count); end
    total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", if0.out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    if2.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if2.in_data = 4'(i); if2.in_valid = 1'b1;
      tick();
      total++; if (if2.in_ready !== 1'b1) begin bad++; $display("FAIL sat_in_ready[%0d]: got %b want 1", i, if2.in_ready); end
      $display("saturation: word=%0d count=%0d", i, if2.out_count);
    end
    if2.in_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (if2.out_count !== 3'd7) begin bad++; $display("FAIL sat_count: got %0d want 7", if2.out_count); end
  endtask

  task automatic test_reset_mid_stall();
    if2.out_ready = 1'b0;
    if2.in_data = 4'd1; if2.in_valid = 1'b1;
    tick();
    if2.in_data = 4'd2;
    tick();
    total++; if (if2.in_ready !== 1'b0) begin bad++; $display("FAIL stall_skid_full: got %b want 0", if2.in_ready); end
    total++; if (if2.out_valid !== 1'b1 || if2.out_codeword !== ref7(4'd1)) begin bad++; $display("FAIL stall_hold: got v=%b cw=%b want v=1 cw=%b", if2.out_valid, if2.out_codeword, ref7(4'd1)); end
    reset = 1'b0;
    tick();
    total++; if (if2.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", if2.out_valid); end
    total++; if (if2.out_count !== 3'd0) begin bad++; $display("FAIL midreset_count: got %0d want 0", if2.out_count); end
    total++; if (if2.in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_ready: got %b want 0", if2.in_ready); end
    reset = 1'b1; if2.in_valid = 1'b0; if2.out_ready = 1'b1;
    tick();
    total++; if (if2.in_ready !== 1'b1 || if2.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_release: got rdy=%b v=%b want rdy=1 v=0", if2.in_ready, if2.out_valid); end
    tick();
    total++; if (if2.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_lost: got %b want 0", if2.out_valid); end
    $display("reset_mid_stall: count=%0d", if2.out_count);
  endtask

  initial begin
    reset = 1'b0;
    idle_all();
    test_reset();
    test_encode();
    test_inject();
    test_secded();
    test_backpressure();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
